// File: rtl/ysyx_22040127_mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22040127_mdu_pkg
// Brief    : Shared types and constants for the iterative multiply/divide unit
// Revision : 1.0 - initial release
// ============================================================================
package ysyx_22040127_mdu_pkg;

    localparam int XLEN = 64;
    localparam int WLEN = 32;
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } mdu_state_t;

    localparam logic [2:0] c_f3_mul    = 3'b000;
    localparam logic [2:0] c_f3_mulh   = 3'b001;
    localparam logic [2:0] c_f3_mulhsu = 3'b010;
    localparam logic [2:0] c_f3_mulhu  = 3'b011;
    localparam logic [2:0] c_f3_div    = 3'b100;
    localparam logic [2:0] c_f3_divu   = 3'b101;
    localparam logic [2:0] c_f3_rem    = 3'b110;
    localparam logic [2:0] c_f3_remu   = 3'b111;

    localparam logic [XLEN-1:0] c_all_ones  = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] c_int64_min = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [WLEN-1:0] c_int32_min = {1'b1, {(WLEN-1){1'b0}}};

    // Down-counter preload values: iterations minus one
    localparam logic [CNT_W-1:0] c_iter_x = CNT_W'(XLEN - 1);
    localparam logic [CNT_W-1:0] c_iter_w = CNT_W'(WLEN - 1);

    function automatic logic [XLEN-1:0] sext_w(input logic [WLEN-1:0] v);
        return {{(XLEN-WLEN){v[WLEN-1]}}, v};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_22040127_mdu_iter.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22040127_mdu_iter
// Brief    : 128-bit accumulator with one shift-add / restoring-divide step
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22040127_mdu_iter
    import ysyx_22040127_mdu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [2*XLEN-1:0] i_load_acc,
    input  logic [XLEN-1:0]   i_load_opnd,
    input  logic              i_step,
    input  logic              i_is_div,
    output logic [2*XLEN-1:0] o_acc
);

    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_opnd;

    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_mul_next;
    logic [XLEN:0]     w_div_trial;
    logic [2*XLEN-1:0] w_div_next;

    // The carry out of the upper-half add becomes the new MSB after the shift
    assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

    // Remainder shifted left with the next dividend bit; bit XLEN set means borrow
    assign w_div_trial = r_acc[2*XLEN-1:XLEN-1] - {1'b0, r_opnd};
    assign w_div_next  = w_div_trial[XLEN] ? {r_acc[2*XLEN-2:0], 1'b0}
                                           : {w_div_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc  <= '0;
            r_opnd <= '0;
        end else if (i_load) begin
            r_acc  <= i_load_acc;
            r_opnd <= i_load_opnd;
        end else if (i_step) begin
            r_acc  <= i_is_div ? w_div_next : w_mul_next;
        end
    end

    assign o_acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/ysyx_22040127_mdu_seq.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22040127_mdu_seq
// Brief    : Iterative RV64M multiply/divide sequencer with valid/ready I/O
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22040127_mdu_seq
    import ysyx_22040127_mdu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    mdu_state_t        r_state, w_state_nxt;
    logic [3:0]        r_op;
    logic              r_neg;
    logic [CNT_W-1:0]  r_cnt;
    logic [XLEN-1:0]   r_result;
    logic [2*XLEN-1:0] w_acc;

    logic              w_word, w_is_div, w_s1_signed, w_s2_signed;
    logic [2:0]        w_f3;
    logic [XLEN-1:0]   w_a, w_b, w_a_mag, w_b_mag, w_dividend, w_corner_res;
    logic              w_a_neg, w_b_neg, w_div_zero, w_ovf, w_corner, w_res_neg, w_accept;
    logic [2*XLEN-1:0] w_load_acc, w_prod;
    logic [XLEN-1:0]   w_quot, w_rem, w_sel, w_fix_res;

    assign w_word   = op[3];
    assign w_f3     = op[2:0];
    assign w_is_div = w_f3[2];
    assign w_s1_signed = !(w_f3 == c_f3_mulhu || w_f3 == c_f3_divu || w_f3 == c_f3_remu);
    assign w_s2_signed = (w_f3 == c_f3_mul || w_f3 == c_f3_mulh ||
                          w_f3 == c_f3_div || w_f3 == c_f3_rem);

    assign w_a = !w_word ? src1 : (w_s1_signed ? sext_w(src1[WLEN-1:0])
                                               : {{(XLEN-WLEN){1'b0}}, src1[WLEN-1:0]});
    assign w_b = !w_word ? src2 : (w_s2_signed ? sext_w(src2[WLEN-1:0])
                                               : {{(XLEN-WLEN){1'b0}}, src2[WLEN-1:0]});
    assign w_a_neg = w_s1_signed & w_a[XLEN-1];
    assign w_b_neg = w_s2_signed & w_b[XLEN-1];
    assign w_a_mag = w_a_neg ? -w_a : w_a;
    assign w_b_mag = w_b_neg ? -w_b : w_b;

    // Corner cases bypass the loop; W results are the 32-bit answer sign-extended
    assign w_dividend = w_word ? sext_w(src1[WLEN-1:0]) : src1;
    assign w_div_zero = (w_b == '0);
    assign w_ovf      = w_is_div & ~w_f3[0] & (w_b == c_all_ones) &
                        (w_a == (w_word ? sext_w(c_int32_min) : c_int64_min));
    assign w_corner   = w_is_div & (w_div_zero | w_ovf);
    assign w_corner_res = w_div_zero ? (w_f3[1] ? w_dividend : c_all_ones)
                                     : (w_f3[1] ? '0 : w_dividend);

    assign w_res_neg = (w_is_div & w_f3[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
    // W divides pre-shift the dividend so 32 steps consume exactly its bits
    assign w_load_acc = (w_is_div & w_word) ? {{XLEN{1'b0}}, w_a_mag[WLEN-1:0], {WLEN{1'b0}}}
                                            : {{XLEN{1'b0}}, w_a_mag};
    assign w_accept = (r_state == S_IDLE) & in_valid & ~flush;

    ysyx_22040127_mdu_iter u_iter (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_accept),
        .i_load_acc  (w_load_acc),
        .i_load_opnd (w_b_mag),
        .i_step      (r_state == S_CALC),
        .i_is_div    (r_op[2]),
        .o_acc       (w_acc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (in_valid) w_state_nxt = w_corner ? S_DONE : S_CALC;
                S_CALC:  if (r_cnt == '0) w_state_nxt = S_FIX;
                S_FIX:   w_state_nxt = S_DONE;
                S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // W mul product sits in acc[127:32] after 32 steps, so its low word is acc[63:32]
    assign w_prod = r_neg ? -w_acc : w_acc;
    assign w_quot = r_neg ? -w_acc[XLEN-1:0] : w_acc[XLEN-1:0];
    assign w_rem  = r_neg ? -w_acc[2*XLEN-1:XLEN] : w_acc[2*XLEN-1:XLEN];

    always_comb begin
        w_sel = '0;
        case (r_op[2:0])
            c_f3_mul:                          w_sel = r_op[3] ? {{(XLEN-WLEN){1'b0}}, w_prod[XLEN-1:WLEN]}
                                                               : w_prod[XLEN-1:0];
            c_f3_mulh, c_f3_mulhsu, c_f3_mulhu: w_sel = r_op[3] ? '0 : w_prod[2*XLEN-1:XLEN];
            c_f3_div, c_f3_divu:               w_sel = w_quot;
            default:                           w_sel = w_rem;
        endcase
    end
    assign w_fix_res = r_op[3] ? sext_w(w_sel[WLEN-1:0]) : w_sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= '0;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_op  <= op;
                r_neg <= w_res_neg;
                r_cnt <= w_word ? c_iter_w : c_iter_x;
                if (w_corner) r_result <= w_corner_res;
            end
            if (r_state == S_CALC && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
            if (r_state == S_FIX && !flush)       r_result <= w_fix_res;
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign result    = r_result;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22040127_mdu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_22040127_mdu_seq
// Brief    : Scoreboard bench for the iterative multiply/divide sequencer
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_22040127_mdu_seq;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, flush, out_valid, out_ready, busy;
    logic [3:0]  op;
    logic [63:0] src1, src2, result;

    always #5 clk = ~clk;

    ysyx_22040127_mdu_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .src1(src1), .src2(src2), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .busy(busy)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] exp;
        int          vcyc;
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
    } sb_t;

    sb_t sbq[$];
    int  total = 0;
    int  bad = 0;
    int  rdy_mode = 0;   // 0: always ready, 1: random, 2: driven by main sequence

    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

    function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endfunction

    function automatic logic [63:0] ref_model(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b);
        logic [127:0]       sa, sb, za, zb, p;
        logic signed [63:0] x, y;
        logic signed [31:0] x32, y32;
        logic [31:0]        a32, b32, r32;
        sa = {{64{a[63]}}, a}; sb = {{64{b[63]}}, b};
        za = {64'd0, a};       zb = {64'd0, b};
        x = a; y = b; a32 = a[31:0]; b32 = b[31:0]; x32 = a32; y32 = b32;
        if (!o[3]) begin
            case (o[2:0])
                3'd0: begin p = za * zb; return p[63:0]; end
                3'd1: begin p = sa * sb; return p[127:64]; end
                3'd2: begin p = sa * zb; return p[127:64]; end
                3'd3: begin p = za * zb; return p[127:64]; end
                3'd4: return (b == 0) ? ONES : ((a == MIN64 && b == ONES) ? a : 64'(x / y));
                3'd5: return (b == 0) ? ONES : a / b;
                3'd6: return (b == 0) ? a : ((a == MIN64 && b == ONES) ? 64'd0 : 64'(x % y));
                default: return (b == 0) ? a : a % b;
            endcase
        end
        case (o[2:0])
            3'd0: r32 = a32 * b32;
            3'd4: r32 = (b32 == 0) ? 32'hFFFF_FFFF : ((a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) ? a32 : 32'(x32 / y32));
            3'd5: r32 = (b32 == 0) ? 32'hFFFF_FFFF : a32 / b32;
            3'd6: r32 = (b32 == 0) ? a32 : ((a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) ? 32'd0 : 32'(x32 % y32));
            3'd7: r32 = (b32 == 0) ? a32 : a32 % b32;
            default: r32 = 32'd0;   // W forms of mulh* are not real instructions
        endcase
        return {{32{r32[31]}}, r32};
    endfunction

    // Cycles from the offer cycle T to the first cycle with out_valid
    function automatic int ref_lat(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b);
        logic zero, ovf;
        zero = o[3] ? (b[31:0] == 0) : (b == 0);
        ovf  = !o[0] && (o[3] ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                              : (a == MIN64 && b == ONES));
        if (o[2] && (zero || ovf)) return 1;
        return o[3] ? 34 : 66;
    endfunction

    // Monitor: pops the scoreboard on every accepted result
    logic        prev_v = 1'b0;
    logic [63:0] prev_res = 64'd0;
    int          rise_cyc = 0;
    always @(negedge clk) begin : mon
        sb_t e;
        if (rdy_mode == 0)      out_ready = 1'b1;
        else if (rdy_mode == 1) out_ready = ($urandom_range(0, 2) != 0);
        if (rst) begin
            prev_v = 1'b0;
        end else begin
            if (out_valid && !prev_v) rise_cyc = cyc;
            if (out_valid && prev_v) check("hold_stable", result, prev_res);
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_result got=%h exp=none", result);
                end else begin
                    e = sbq.pop_front();
                    total++;
                    if (result !== e.exp) begin
                        bad++;
                        $display("FAIL result op=%h a=%h b=%h got=%h exp=%h", e.op, e.a, e.b, result, e.exp);
                    end
                    check("valid_cycle", 64'(rise_cyc), 64'(e.vcyc));
                end
            end
            prev_v   = out_valid;
            prev_res = result;
        end
    end

    task automatic issue(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b,
                         input bit push, output int t);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 400) begin @(negedge clk); n++; end
        t = cyc;
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL issue_timeout got=in_ready_low exp=in_ready_high");
            return;
        end
        in_valid = 1'b1; op = o; src1 = a; src2 = b;
        if (push) sbq.push_back('{exp: ref_model(o, a, b), vcyc: t + ref_lat(o, a, b), op: o, a: a, b: b});
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sbq.size() != 0 || out_valid) && n < 600) begin @(negedge clk); n++; end
        check("drain", 64'(sbq.size()), 64'd0);
    endtask

    function automatic logic [63:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return {$urandom, $urandom};
            1: return 64'($signed($urandom_range(0, 40)) - 20);
            2: return 64'd0;
            3: return ONES;
            4: return MIN64;
            default: return {$urandom, 32'h8000_0000};
        endcase
    endfunction

    logic [3:0]  d_op [11] = '{4'h0, 4'h3, 4'h1, 4'h4, 4'h6, 4'hD, 4'h4, 4'h7, 4'hC, 4'hE, 4'h9};
    logic [63:0] d_a  [11] = '{64'd7, ONES, MIN64, -64'sd7, -64'sd7, 64'h8000_0000,
                               64'd5, 64'd5, 64'h8000_0000, 64'h8000_0000, 64'd9};
    logic [63:0] d_b  [11] = '{-64'sd3, ONES, MIN64, 64'd2, 64'd2, 64'd1,
                               64'd0, 64'd0, ONES, ONES, 64'd9};

    initial begin : wdog
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int t, errs, vcount;
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        op = '0; src1 = '0; src2 = '0;
        repeat (3) @(negedge clk);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_result", result, 64'd0);
        rst = 1'b0;

        // mul 7 * -3 with the busy window T+1..T+66
        issue(4'h0, 64'd7, -64'sd3, 1'b1, t);
        errs = 0;
        for (int k = 1; k <= 66; k++) begin
            if (busy !== 1'b1) errs++;
            @(negedge clk);
        end
        check("busy_window_errors", 64'(errs), 64'd0);
        check("busy_after_accept", 64'(busy), 64'd0);
        drain();

        for (int i = 0; i < 11; i++) issue(d_op[i], d_a[i], d_b[i], 1'b1, t);
        drain();

        // Result held while the consumer stalls, then one-cycle handshake
        rdy_mode = 2;
        out_ready = 1'b0;
        issue(4'h0, 64'd3, 64'd5, 1'b1, t);
        vcount = 0;
        while (!out_valid && vcount < 200) begin @(negedge clk); vcount++; end
        errs = 0;
        for (int k = 0; k < 10; k++) begin
            if (out_valid !== 1'b1 || result !== 64'd15 || in_ready !== 1'b0) errs++;
            @(negedge clk);
        end
        check("stall_hold_errors", 64'(errs), 64'd0);
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        check("no_same_cycle_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1 out_ready = 1'b0;
        @(negedge clk);
        check("ready_after_handshake", 64'(in_ready), 64'd1);
        check("valid_after_handshake", 64'(out_valid), 64'd0);
        rdy_mode = 0;

        // Flush at T+20 of a divide, with a competing in_valid
        issue(4'h4, 64'd1000, 64'd7, 1'b0, t);
        while (cyc < t + 20) @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; op = 4'h0; src1 = 64'd2; src2 = 64'd2;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        vcount = 0;
        for (int k = 0; k < 80; k++) begin
            if (out_valid) vcount++;
            @(negedge clk);
        end
        check("flush_no_valid", 64'(vcount), 64'd0);

        // Asynchronous reset mid-CALC
        issue(4'h0, 64'h1234_5678_9ABC_DEF0, 64'd99, 1'b0, t);
        while (cyc < t + 10) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_result", result, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        issue(4'h0, 64'd3, 64'd4, 1'b1, t);
        drain();

        // Randomised traffic with a throttled consumer
        rdy_mode = 1;
        for (int i = 0; i < 60; i++)
            issue(4'($urandom_range(0, 15)), pick_operand(), pick_operand(), 1'b1, t);
        drain();
        rdy_mode = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
